// File: rtl/servo_scan_seq_pkg.sv
// Shared types and constants for the servo scan sequencer.
// Position codes match the PWM stage's 2-bit input; defaults assume a 50 MHz clock.
package servo_scan_seq_pkg;

   localparam int unsigned SETTLE_CYCLES_DEF = 12_500_000;
   localparam int unsigned MEAS_TIMEOUT_DEF  = 1_500_000;
   localparam int unsigned DIST_W_DEF        = 16;

   localparam logic [1:0] POS_0    = 2'b00;
   localparam logic [1:0] POS_1    = 2'b01;
   localparam logic [1:0] POS_2    = 2'b10;
   localparam logic [1:0] POS_PARK = POS_1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE,
      ST_SETTLE,
      ST_TRIG,
      ST_WAIT,
      ST_NEXT,
      ST_FINISH
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/servo_scan_seq_cycle_timer.sv
// Clear/enable up-counter with terminal-count compare, shared by SETTLE and WAIT.
// Holds at the terminal count so it can never wrap inside a state.
module cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == tc_val_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/servo_scan_seq.sv
// Servo scan sequencer: steps the PWM position through 00/01/10, settles, takes one
// ultrasonic range reading per position, then parks at centre and pulses done.
module servo_scan_seq
   import servo_scan_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned MEAS_TIMEOUT  = MEAS_TIMEOUT_DEF,
   parameter int unsigned DIST_W        = DIST_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [1:0]        pos,
   output logic              us_trig,
   input  logic              us_done,
   input  logic [DIST_W-1:0] us_dist,
   output logic [DIST_W-1:0] dist0,
   output logic [DIST_W-1:0] dist1,
   output logic [DIST_W-1:0] dist2,
   output logic [2:0]        tmo
);

   localparam int unsigned TW = $clog2(max2(SETTLE_CYCLES, MEAS_TIMEOUT) + 1);
   localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] MEAS_TC   = TW'(MEAS_TIMEOUT - 1);

   state_e                   state_q;
   logic [1:0]               idx_q;
   logic [1:0]               pos_q;
   logic                     busy_q, done_q, trig_q;
   logic [2:0][DIST_W-1:0]   dist_q;
   logic [2:0]               tmo_q;

   logic                     tmr_clr, tmr_en, tmr_tc;
   logic [TW-1:0]            tmr_tc_val;

   // Timer restarts from zero on entry to SETTLE (via MOVE) and WAIT (via TRIG).
   assign tmr_clr    = (state_q == ST_MOVE) || (state_q == ST_TRIG);
   assign tmr_en     = (state_q == ST_SETTLE) || (state_q == ST_WAIT);
   assign tmr_tc_val = (state_q == ST_WAIT) ? MEAS_TC : SETTLE_TC;

   cycle_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .tc_val_i (tmr_tc_val),
      .tc_o     (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pos_q   <= POS_PARK;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         trig_q  <= 1'b0;
         dist_q  <= '0;
         tmo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         trig_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               state_q <= ST_MOVE;
               busy_q  <= 1'b1;
               idx_q   <= '0;
               dist_q  <= '0;
               tmo_q   <= '0;
            end
            ST_MOVE: begin
               pos_q   <= idx_q;
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: if (tmr_tc) begin
               trig_q  <= 1'b1;
               state_q <= ST_TRIG;
            end
            ST_TRIG: state_q <= ST_WAIT;
            // A result arriving on the timeout cycle still counts as a valid reading.
            ST_WAIT: if (us_done) begin
               dist_q[idx_q] <= us_dist;
               state_q       <= ST_NEXT;
            end else if (tmr_tc) begin
               dist_q[idx_q] <= '1;
               tmo_q[idx_q]  <= 1'b1;
               state_q       <= ST_NEXT;
            end
            ST_NEXT: if (idx_q == 2'd2) begin
               pos_q   <= POS_PARK;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_FINISH;
            end else begin
               idx_q   <= idx_q + 2'd1;
               state_q <= ST_MOVE;
            end
            ST_FINISH: state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign pos     = pos_q;
   assign us_trig = trig_q;
   assign dist0   = dist_q[0];
   assign dist1   = dist_q[1];
   assign dist2   = dist_q[2];
   assign tmo     = tmo_q;

endmodule

// File: tb/tb_servo_scan_seq.sv
// Directed bench for servo_scan_seq: table of whole-scan scenarios with a cycle-level
// responder, plus hand sequences for reset mid-scan and back-to-back starts.
module tb_servo_scan_seq;
   import servo_scan_seq_pkg::*;

   localparam int S    = 10;
   localparam int M    = 20;
   localparam int DW   = 16;
   localparam int NONE = 255;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          us_done = 1'b0;
   logic [DW-1:0] us_dist = '0;
   logic          busy, done, us_trig;
   logic [1:0]    pos;
   logic [DW-1:0] dist0, dist1, dist2;
   logic [2:0]    tmo;

   int ntest = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   servo_scan_seq #(.SETTLE_CYCLES(S), .MEAS_TIMEOUT(M), .DIST_W(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .pos     (pos),
      .us_trig (us_trig),
      .us_done (us_done),
      .us_dist (us_dist),
      .dist0   (dist0),
      .dist1   (dist1),
      .dist2   (dist2),
      .tmo     (tmo)
   );

   typedef struct {
      logic [2:0][7:0]    dly;   // cycles from us_trig to us_done, NONE = no reply
      logic [2:0][DW-1:0] val;
      bit                 noise; // extra starts and stray us_done pulses
      logic [DW-1:0]      e0, e1, e2;
      logic [2:0]         etmo;
   } scan_t;

   scan_t tbl[6];
   scan_t abort_rec;

   function automatic scan_t mk(input int d0, input int d1, input int d2,
                                input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                input logic [DW-1:0] v2, input bit nz,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2, input logic [2:0] et);
      scan_t r;
      r.dly[0] = 8'(d0); r.dly[1] = 8'(d1); r.dly[2] = 8'(d2);
      r.val[0] = v0;     r.val[1] = v1;     r.val[2] = v2;
      r.noise = nz;
      r.e0 = e0; r.e1 = e1; r.e2 = e2; r.etmo = et;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Cycle k is observed at its negedge; inputs set there are sampled at the edge ending cycle k.
   task automatic run_scan(input scan_t r, input int tail, input bit abort);
      int exp_trig, exp_done, ntrig, ndone, pend, pidx, eff, npos, abort_k;
      logic [1:0] pprev;
      logic [1:0] pseq[4];
      exp_trig = 1 + 1 + S;
      exp_done = -1;
      ntrig = 0; ndone = 0; pend = -1; pidx = 0; npos = 0; abort_k = -1;
      for (int i = 0; i < 4; i++) pseq[i] = 2'b11;
      @(negedge clk);
      start = 1'b1;
      pprev = pos;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = 1'b0; us_done = 1'b0; us_dist = '0;
         if (r.noise && (k == 3 || k == 40)) start = 1'b1;
         if (r.noise && (k == 4 || k == 7)) begin us_done = 1'b1; us_dist = 16'hDEAD; end
         if (k == 1) begin
            chk("busy_on", busy, 1);
            chk("clear_at_start", {dist0, dist1, dist2, tmo}, '0);
         end
         if (k == 2) chk("pos0_time", pos, POS_0);
         if (pos != pprev) begin
            if (npos < 4) pseq[npos] = pos;
            npos++;
            pprev = pos;
         end
         if (us_trig) begin
            if (ntrig >= 3) chk("trig_count", ntrig + 1, 3);
            else begin
               chk($sformatf("trig%0d_time", ntrig), k, exp_trig);
               eff = (r.dly[ntrig] <= M) ? int'(r.dly[ntrig]) : M;
               pend = k + int'(r.dly[ntrig]);
               pidx = ntrig;
               if (ntrig == 2) exp_done = k + eff + 2;
               else            exp_trig = k + eff + 1 + 1 + S + 1;
               ntrig++;
               if (abort && ntrig == 3) abort_k = k + 3;
            end
         end
         if (k == pend) begin us_done = 1'b1; us_dist = r.val[pidx]; pend = -1; end
         if (k == abort_k) begin
            us_done = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_pos", pos, POS_PARK);
            chk("async_rst_busy", busy, 0);
            chk("async_rst_outs", {done, us_trig, dist0, dist1, dist2, tmo}, '0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (done) begin
            ndone++;
            chk("done_time", k, exp_done);
            chk("busy_at_done", busy, 0);
            chk("park_pos", pos, POS_PARK);
            chk("dist0", dist0, r.e0);
            chk("dist1", dist1, r.e1);
            chk("dist2", dist2, r.e2);
            chk("tmo", tmo, r.etmo);
            chk("ntrig", ntrig, 3);
            chk("pos_seq", {pseq[0], pseq[1], pseq[2], pseq[3], 8'(npos)},
                {POS_0, POS_1, POS_2, POS_PARK, 8'd4});
            if (r.noise) start = 1'b1;  // lands in the FINISH cycle
            break;
         end
      end
      chk("scan_completed", ndone, 1);
      for (int t = 0; t < tail; t++) begin
         @(negedge clk);
         start = 1'b0;
         us_done = (t == 0);
         us_dist = 16'hBEEF;
         chk("done_single", done, 0);
         chk("idle_busy", busy, 0);
         chk("hold_results", {dist0, dist1, dist2, tmo}, {r.e0, r.e1, r.e2, r.etmo});
      end
      us_done = 1'b0;
   endtask

   initial begin
      tbl[0] = mk(5, 5, 5,       100, 200, 300, 0, 100, 200, 300, 3'b000);
      tbl[1] = mk(5, NONE, 5,    100, 200, 300, 0, 100, 16'hFFFF, 300, 3'b010);
      tbl[2] = mk(M, 5, 5,       42, 200, 300,  0, 42, 200, 300, 3'b000);
      tbl[3] = mk(5, 5, 5,       100, 200, 300, 1, 100, 200, 300, 3'b000);
      tbl[4] = mk(5, 5, M + 1,   7, 8, 9,       0, 7, 8, 16'hFFFF, 3'b100);
      tbl[5] = mk(NONE, NONE, NONE, 1, 2, 3,    0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b111);
      abort_rec = mk(5, 5, NONE, 100, 200, 300, 0, 0, 0, 0, 3'b000);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pos", pos, POS_PARK);
      chk("rst_ctrl", {busy, done, us_trig}, 3'b000);
      chk("rst_results", {dist0, dist1, dist2, tmo}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_scan(tbl[i], 3, 0);
      end

      run_scan(abort_rec, 0, 1);
      repeat (2) @(negedge clk);
      run_scan(tbl[0], 0, 0);
      run_scan(tbl[1], 2, 0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule

// File: doc/servo_scan_seq.md
# servo_scan_seq

Scan sequencer that sits directly upstream of the servo PWM generator and drives its 2-bit position code. On a start pulse it steps the servo through position codes 0, 1 and 2. At each position it waits a mechanical settle time, requests one ultrasonic range measurement, and latches the result. It then parks the servo at code 1 (centre) and signals completion.

## Interface
- SETTLE_CYCLES, 12_500_000, cycles to wait after each position change (250 ms at 50 MHz)
- MEAS_TIMEOUT, 1_500_000, max cycles to wait for a range result (30 ms at 50 MHz)
- DIST_W, 16, width of range values

- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  scan request, sampled on rising clk; ignored while busy
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when scan completes
- pos  out  2  position code to PWM stage: 00, 01, 10 (11 never driven)
- us_trig  out  1  one-cycle measurement request to ranging block
- us_done  in  1  one-cycle pulse, result valid on us_dist
- us_dist  in  DIST_W  range result, valid only with us_done
- dist0, dist1, dist2  out  DIST_W each  latched range at pos 00, 01 and 10
- tmo  out  3  bit i set if measurement at pos i timed out

## Operation
- Reset values: pos=01, busy=0, done=0, us_trig=0, dist0..2=0, tmo=000, state IDLE.
- States:
  - IDLE: on start go to MOVE and clear dist0..2 and tmo; busy=1.
  - MOVE: drive pos=idx, clear timer, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to TRIG.
  - TRIG: us_trig=1 for one cycle, clear timer, go to WAIT.
  - WAIT: on us_done, latch us_dist into dist[idx] and go to NEXT. If the timer reaches MEAS_TIMEOUT first, set dist[idx] to all ones, set tmo[idx], and go to NEXT.
  - NEXT: if idx==2, go to FINISH; otherwise idx+1 and go to MOVE.
  - FINISH: pos=01, done=1 for one cycle, busy=0, go to IDLE.
- idx is a 2-bit scan index that resets to 0 on every accepted start.
- Boundary conditions:
  - us_done in the same cycle the timeout expires: us_done wins; the value is stored and no tmo bit is set.
  - us_done outside WAIT: ignored.
  - start while busy: ignored, with no queuing.
  - start in the FINISH cycle: ignored.
  - rst_n low at any time: immediate return to reset values. A measurement in flight is abandoned.
- Results hold stable from done until the next accepted start.

## Timing
- start high at edge N: busy=1 and state MOVE after N. pos=00 after N+1.
- SETTLE occupies exactly SETTLE_CYCLES cycles. us_trig is high in the single cycle after SETTLE.
- The WAIT timer starts at 0 in the first WAIT cycle. The timeout fires on the cycle the count equals MEAS_TIMEOUT-1 with no us_done.
- A result captured on the edge where us_done=1 is visible on dist[idx] the following cycle.
- Each position therefore takes 1 (MOVE) + SETTLE_CYCLES + 1 (TRIG) + wait + 1 (NEXT) cycles.
- done and busy falling occur in the same cycle. pos=01 appears in that cycle.
- Timer width: $clog2 of max(SETTLE_CYCLES, MEAS_TIMEOUT)+1. No wrap is permitted within a state.

## Structure
- Shared package holds:
  - position codes POS_0=2'b00, POS_1=2'b01, POS_2=2'b10, POS_PARK=POS_1
  - the state enum
  - the default timing constants at 50 MHz
- One sub-module, cycle_timer: a clear/enable up-counter with a terminal-count compare. It is shared by SETTLE and WAIT, and only one instance is required.

## Test plan
Bench uses SETTLE_CYCLES=10 and MEAS_TIMEOUT=20.
- Normal scan: start, with the responder returning us_done 5 cycles after each us_trig with values 100, 200, 300 -> pos sequence 00, 01, 10, then 01; dist0/1/2 = 100/200/300; tmo=000; exactly one done pulse; us_trig spacing checked.
- Timeout: no us_done at pos 01 -> dist1=FFFF, tmo=010, remaining positions unaffected; us_trig exactly 20 WAIT cycles before the timeout transition.
- Collision: us_done on the exact timeout cycle at pos 00 with value 42 -> dist0=42, tmo[0]=0.
- Start while busy, plus spurious us_done pulses during SETTLE -> no restart, ignored pulses, results identical to the normal scan.
- Reset mid-scan: rst_n low during WAIT at pos 10 -> outputs return to reset values asynchronously (pos=01, busy=0). A subsequent start performs a full, clean scan.
- Back-to-back: start asserted the cycle after done -> second scan accepted; dist/tmo cleared at acceptance.
